// File: rtl/dram_burst_engine.sv
// dram_burst_engine: data-path sequencer between the memory scheduler and the
// DIMM data bus. Column commands get data-bus slots in acceptance order. Write
// lines are driven at CWL and read lines are captured at CAS_LATENCY. Read lines
// come back through a first-word-fall-through response FIFO, and a single credit
// pool covers in-flight ops and held responses.
// Optional feature macro: DRAM_BURST_CHOP_EN (adds issue_chop_in, half-length bursts).
module dram_burst_engine #(
    parameter int DATA_W          = 64,
    parameter int BURST_LEN       = 8,
    parameter int PADDR_BITS      = 64,
    parameter int CAS_LATENCY     = 22,
    parameter int CWL             = 16,
    parameter int TURNAROUND      = 1,
    parameter int MAX_OUTSTANDING = 8,
    parameter int TS_BITS         = 16
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            issue_valid_in,
    output logic                            issue_ready_out,
    input  logic                            issue_write_in,
    input  logic [PADDR_BITS-1:0]           issue_paddr_in,
    input  logic [BURST_LEN*DATA_W-1:0]     issue_wdata_in,
`ifdef DRAM_BURST_CHOP_EN
    input  logic                            issue_chop_in,
`endif
    input  logic [DATA_W-1:0]               dq_in,
    output logic [DATA_W-1:0]               dq_out,
    output logic                            dq_oe_out,
    output logic                            rd_valid_out,
    input  logic                            rd_ready_in,
    output logic [PADDR_BITS-1:0]           rd_paddr_out,
    output logic [BURST_LEN*DATA_W-1:0]     rd_data_out,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding_out
);

    localparam int CW     = $clog2(MAX_OUTSTANDING) + 1;
    localparam int PW     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int BW     = $clog2(BURST_LEN);
    localparam int LINE_W = BURST_LEN * DATA_W;
    localparam logic [TS_BITS-1:0] FULL_LEN = TS_BITS'(BURST_LEN);
    localparam logic [TS_BITS-1:0] HALF_LEN = TS_BITS'(BURST_LEN / 2);

    // scheduling state
    logic [TS_BITS-1:0] cnt;
    logic [TS_BITS-1:0] bus_free_at;
    logic               last_dir;       // 1 = write
    logic [CW-1:0]      outstanding;

    // tracking FIFO (ops holding a bus slot)
    logic                  t_write [MAX_OUTSTANDING];
    logic                  t_chop  [MAX_OUTSTANDING];
    logic [PADDR_BITS-1:0] t_paddr [MAX_OUTSTANDING];
    logic [TS_BITS-1:0]    t_start [MAX_OUTSTANDING];
    logic [LINE_W-1:0]     t_wdata [MAX_OUTSTANDING];
    logic [PW-1:0]         t_rd;
    logic [PW-1:0]         t_wr;
    logic [CW-1:0]         t_count;

    // response FIFO (completed reads)
    logic [PADDR_BITS-1:0] r_paddr [MAX_OUTSTANDING];
    logic [LINE_W-1:0]     r_data  [MAX_OUTSTANDING];
    logic [PW-1:0]         r_rd;
    logic [PW-1:0]         r_wr;
    logic [CW-1:0]         r_count;

    // combinational
    logic                  chop_req;
    logic [TS_BITS-1:0]    start_req;
    logic [TS_BITS-1:0]    req_free;
    logic [TS_BITS-1:0]    slack;
    logic [TS_BITS-1:0]    req_len;
    logic [TS_BITS-1:0]    free_gap;
    logic                  accept;
    logic [TS_BITS-1:0]    h_off;
    logic [TS_BITS-1:0]    h_len;
    logic                  h_active;
    logic                  h_last;
    logic [BW-1:0]         h_beat;
    logic [PW-1:0]         n;
    logic                  n_valid;
    logic [TS_BITS-1:0]    n_off;
    logic [TS_BITS-1:0]    n_len;
    logic                  n_active;
    logic [LINE_W-1:0]     n_data;
    logic [DATA_W-1:0]     next_beat;
    logic                  rd_beat;
    logic                  wr_done;
    logic                  rd_done;
    logic                  r_pop;
    logic [LINE_W-1:0]     line;
    logic [LINE_W-1:0]     captured;
    logic [LINE_W-1:0]     resp_line;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(MAX_OUTSTANDING - 1)) return '0;
        return p + PW'(1);
    endfunction

`ifdef DRAM_BURST_CHOP_EN
    assign chop_req = issue_chop_in;
`else
    assign chop_req = 1'b0;
`endif

    // Admission: credit available and the new burst cannot start before the bus is free.
    always_comb begin
        start_req       = cnt + (issue_write_in ? TS_BITS'(CWL) : TS_BITS'(CAS_LATENCY));
        req_free        = bus_free_at + ((issue_write_in != last_dir) ? TS_BITS'(TURNAROUND) : '0);
        slack           = start_req - req_free;
        req_len         = chop_req ? HALF_LEN : FULL_LEN;
        free_gap        = bus_free_at - cnt;
        issue_ready_out = !rst_in && (outstanding < CW'(MAX_OUTSTANDING)) && !slack[TS_BITS-1];
    end

    assign accept = issue_valid_in && issue_ready_out;

    // Head op owns the bus in this cycle. The op that owns the next cycle is looked up
    // here too, so the registered write drive can chain back-to-back bursts.
    always_comb begin
        h_off    = cnt - t_start[t_rd];
        h_len    = t_chop[t_rd] ? HALF_LEN : FULL_LEN;
        h_active = (t_count != '0) && !h_off[TS_BITS-1] && (h_off < h_len);
        h_last   = h_active && (h_off == h_len - TS_BITS'(1));
        h_beat   = h_off[BW-1:0];
        n        = h_last ? ptr_inc(t_rd) : t_rd;
        n_valid  = h_last ? (t_count > CW'(1)) : (t_count != '0);
        n_off    = cnt + TS_BITS'(1) - t_start[n];
        n_len    = t_chop[n] ? HALF_LEN : FULL_LEN;
        n_active = n_valid && t_write[n] && !n_off[TS_BITS-1] && (n_off < n_len);
        n_data   = t_wdata[n];
        next_beat = n_data[int'(n_off[BW-1:0])*DATA_W +: DATA_W];
        rd_beat  = h_active && !t_write[t_rd];
        wr_done  = h_last && t_write[t_rd];
        rd_done  = h_last && !t_write[t_rd];
    end

    // Merge the beat on the bus into the line being captured. A chopped read returns a zero upper half.
    always_comb begin
        captured = line;
        captured[int'(h_beat)*DATA_W +: DATA_W] = dq_in;
        resp_line = captured;
        if (t_chop[t_rd]) resp_line[LINE_W-1 -: LINE_W/2] = '0;
    end

    assign r_pop           = (r_count != '0) && rd_ready_in;
    assign rd_valid_out    = (r_count != '0);
    assign rd_paddr_out    = (r_count != '0) ? r_paddr[r_rd] : '0;
    assign rd_data_out     = (r_count != '0) ? r_data[r_rd] : '0;
    assign outstanding_out = outstanding;

    // Timestamp, bus reservation and credit accounting.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt         <= '0;
            bus_free_at <= '0;
            last_dir    <= 1'b0;
            outstanding <= '0;
        end else begin
            cnt <= cnt + TS_BITS'(1);
            if (accept) begin
                bus_free_at <= start_req + req_len;
                last_dir    <= issue_write_in;
            end else if (free_gap[TS_BITS-1]) begin
                // An idle bus is pulled up to "now" so the signed compare never ages past half the counter range.
                bus_free_at <= cnt;
            end
            outstanding <= outstanding + CW'(accept) - CW'(wr_done) - CW'(r_pop);
        end
    end

    // Tracking FIFO pointers: push on accept, pop after the head's last beat.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            t_rd    <= '0;
            t_wr    <= '0;
            t_count <= '0;
        end else begin
            if (accept) t_wr <= ptr_inc(t_wr);
            if (h_last) t_rd <= ptr_inc(t_rd);
            t_count <= t_count + CW'(accept) - CW'(h_last);
        end
    end

    // Tracking FIFO storage.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            t_write[t_wr] <= issue_write_in;
            t_chop[t_wr]  <= chop_req;
            t_paddr[t_wr] <= issue_paddr_in;
            t_start[t_wr] <= start_req;
            t_wdata[t_wr] <= issue_wdata_in;
        end
    end

    // Response FIFO pointers: push on read completion, pop on consumer handshake.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (rd_done) r_wr <= ptr_inc(r_wr);
            if (r_pop)   r_rd <= ptr_inc(r_rd);
            r_count <= r_count + CW'(rd_done) - CW'(r_pop);
        end
    end

    // Response FIFO storage.
    always_ff @(posedge clk_in) begin
        if (rd_done) begin
            r_paddr[r_wr] <= t_paddr[t_rd];
            r_data[r_wr]  <= resp_line;
        end
    end

    // Registered write drive for the next cycle, and read beat capture.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            dq_oe_out <= 1'b0;
            dq_out    <= '0;
            line      <= '0;
        end else begin
            dq_oe_out <= n_active;
            dq_out    <= n_active ? next_beat : '0;
            if (rd_beat) line <= captured;
        end
    end

endmodule

// File: tb/tb_dram_burst_engine.sv
// Bench for dram_burst_engine: a table of directed scheduling scenarios, hand
// sequences for backpressure and mid-burst reset, and random traffic. All of it
// is checked every cycle against a timestamp-based reference model.
module tb_dram_burst_engine;
    localparam int DW = 64, BL = 8, PB = 64, CL = 22, CWLAT = 16, TA = 1, MAXO = 8, TSB = 16;
    localparam int LW = DW * BL;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, iv, iready, iw, oe, rv, rr;
    logic [PB-1:0] ipaddr, rpaddr;
    logic [LW-1:0] iwdata, rdata;
    logic [DW-1:0] dqi, dqo;
    logic [$clog2(MAXO):0] outst;
`ifdef DRAM_BURST_CHOP_EN
    logic chop = 1'b0;
`endif

    dram_burst_engine #(
        .DATA_W(DW), .BURST_LEN(BL), .PADDR_BITS(PB), .CAS_LATENCY(CL),
        .CWL(CWLAT), .TURNAROUND(TA), .MAX_OUTSTANDING(MAXO), .TS_BITS(TSB)
    ) dut (
        .clk_in(clk), .rst_in(rst),
        .issue_valid_in(iv), .issue_ready_out(iready), .issue_write_in(iw),
        .issue_paddr_in(ipaddr), .issue_wdata_in(iwdata),
`ifdef DRAM_BURST_CHOP_EN
        .issue_chop_in(chop),
`endif
        .dq_in(dqi), .dq_out(dqo), .dq_oe_out(oe),
        .rd_valid_out(rv), .rd_ready_in(rr), .rd_paddr_out(rpaddr), .rd_data_out(rdata),
        .outstanding_out(outst)
    );

    int passed = 0, total = 0;

    // reference model: absolute cycle numbers, no wrap
    int m_cnt, bus_free;
    bit last_w;
    typedef struct { int start; logic [LW-1:0] data; } wr_t;
    typedef struct { int start; logic [PB-1:0] paddr; } rd_t;
    wr_t wq[$];
    rd_t rq[$];

    // per-step DUT observations
    bit obs_acc, s_oe, s_rv;
    logic [DW-1:0] s_dq;
    logic [PB-1:0] s_pa;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s t=%0d: got %0h expected %0h", name, m_cnt, act, exp);
    endtask

    function automatic logic [DW-1:0] dq_pat(input int t);
        logic [31:0] hi;
        hi = 32'(t) * 32'h9E3779B1;
        return {hi, 32'(t + 'h80)};
    endfunction

    function automatic logic [LW-1:0] exp_line(input int s);
        logic [LW-1:0] l;
        for (int k = 0; k < BL; k++) l[k*DW +: DW] = dq_pat(s + k);
        return l;
    endfunction

    function automatic bit model_ready(input bit w);
        int start;
        if (wq.size() + rq.size() >= MAXO) return 1'b0;
        start = m_cnt + (w ? CWLAT : CL);
        return start >= bus_free + ((w != last_w) ? TA : 0);
    endfunction

    function automatic void model_clear();
        m_cnt = 0; bus_free = 0; last_w = 1'b0;
        wq.delete(); rq.delete();
    endfunction

    // One clock cycle: drive, compare against the model, advance the model across the edge.
    task automatic step(input bit v, input bit w, input logic [PB-1:0] pa, input logic [LW-1:0] wd,
                        input bit rready, output bit acc);
        bit eoe, ev, er;
        logic [DW-1:0] edq;
        logic [LW-1:0] tmp;
        int st;
        iv = v; iw = w; ipaddr = pa; iwdata = wd; rr = rready; dqi = dq_pat(m_cnt);
        while (wq.size() > 0 && wq[0].start + BL <= m_cnt) void'(wq.pop_front());
        #1;
        eoe = (wq.size() > 0) && (wq[0].start <= m_cnt);
        edq = '0;
        if (eoe) begin
            tmp = wq[0].data;
            edq = tmp[(m_cnt - wq[0].start)*DW +: DW];
        end
        ev = (rq.size() > 0) && (rq[0].start + BL <= m_cnt);
        er = model_ready(w);
        check("dq_oe", oe, eoe);
        check("dq_out", dqo, edq);
        check("rd_valid", rv, ev);
        if (ev) begin
            check("rd_paddr", rpaddr, rq[0].paddr);
            check("rd_data", rdata, exp_line(rq[0].start));
        end
        check("outstanding", outst, wq.size() + rq.size());
        check("issue_ready", iready, er);
        obs_acc = v && iready; s_oe = oe; s_dq = dqo; s_rv = rv; s_pa = rpaddr;
        acc = v && er;
        if (ev && rready) void'(rq.pop_front());
        if (acc) begin
            st = m_cnt + (w ? CWLAT : CL);
            if (w) wq.push_back('{st, wd});
            else   rq.push_back('{st, pa});
            bus_free = st + BL;
            last_w = w;
        end
        @(posedge clk);
        m_cnt++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; iv = 1'b0; iw = 1'b0; ipaddr = '0; iwdata = '0; rr = 1'b0; dqi = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_ready", iready, 0);
        check("rst_oe", oe, 0);
        check("rst_dq", dqo, 0);
        check("rst_valid", rv, 0);
        check("rst_paddr", rpaddr, 0);
        check("rst_data", rdata, 0);
        check("rst_outst", outst, 0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    typedef struct { bit w0; int c0; bit two; bit w1; int c1; int exp_acc; int exp_ev; } vec_t;
    vec_t vecs[6];

    logic [LW-1:0] wd0, wd1, rwd;
    bit a, p0, p1, off0, off1, lw, rrdy, v, w;
    int acc_t, ev_t, t_now, n, rt;
    logic [PB-1:0] pa;

    initial begin
        // w0 c0 two w1 c1 -> cycle of last accept, cycle its data first appears
        vecs[0] = '{1'b0, 10, 1'b0, 1'b0, 0, 10, 40};  // single read: valid at 10+22+8
        vecs[1] = '{1'b1,  5, 1'b0, 1'b0, 0,  5, 21};  // single write: oe from 5+16
        vecs[2] = '{1'b0,  0, 1'b1, 1'b0, 1,  8, 38};  // read after read: start 30
        vecs[3] = '{1'b0,  0, 1'b1, 1'b1, 1, 15, 31};  // write after read: start 30+1
        vecs[4] = '{1'b1,  0, 1'b1, 1'b1, 1,  8, 24};  // write after write: start 24
        vecs[5] = '{1'b1,  0, 1'b1, 1'b0, 1,  3, 33};  // read after write: start 25
        for (int k = 0; k < BL; k++) begin
            wd0[k*DW +: DW] = 64'(16'h10 + k);
            wd1[k*DW +: DW] = 64'(16'h20 + k);
        end

        for (int i = 0; i < 6; i++) begin
            do_reset();
            p0 = 1'b1; p1 = vecs[i].two; acc_t = -1; ev_t = -1;
            lw = vecs[i].two ? vecs[i].w1 : vecs[i].w0;
            for (int c = 0; c < 90; c++) begin
                t_now = m_cnt;
                off0 = p0 && (m_cnt >= vecs[i].c0);
                off1 = !p0 && p1 && (m_cnt >= vecs[i].c1);
                if (off0)      step(1'b1, vecs[i].w0, 64'h1C0, wd0, 1'b1, a);
                else if (off1) step(1'b1, vecs[i].w1, 64'h2C0, wd1, 1'b1, a);
                else           step(1'b0, 1'b0, '0, '0, 1'b1, a);
                if (obs_acc) begin
                    if (off0) p0 = 1'b0; else p1 = 1'b0;
                    acc_t = t_now;
                end
                if (ev_t < 0 && (lw ? (s_oe && s_dq == (vecs[i].two ? 64'h20 : 64'h10))
                                    : (s_rv && s_pa == (vecs[i].two ? 64'h2C0 : 64'h1C0))))
                    ev_t = t_now;
            end
            check($sformatf("vec%0d_accept_cycle", i), acc_t, vecs[i].exp_acc);
            check($sformatf("vec%0d_data_cycle", i), ev_t, vecs[i].exp_ev);
        end

        // backpressure: fill every credit with held reads, then drain in order
        do_reset();
        n = 0;
        for (int c = 0; c < 100; c++) begin
            step(1'b1, 1'b0, 64'h1000 + 64'(c * 64), '0, 1'b0, a);
            if (obs_acc) n++;
        end
        check("bp_accepts", n, MAXO);
        #1;
        check("bp_held_outst", outst, MAXO);
        check("bp_ready_low", iready, 0);
        @(negedge clk);
        m_cnt++;
        for (int c = 0; c < 80; c++) step(1'b1, 1'b0, 64'h8000 + 64'(c * 64), '0, 1'b1, a);
        for (int c = 0; c < 60; c++) step(1'b0, 1'b0, '0, '0, 1'b1, a);

        // asynchronous reset in the middle of a write burst
        do_reset();
        for (int c = 0; c < 24; c++) step(m_cnt == 5, 1'b1, '0, wd0, 1'b1, a);
        #1;
        check("mid_oe_before", oe, 1);
        check("mid_dq_before", dqo, 64'h13);
        #1 rst = 1'b1;
        #1;
        check("mid_oe_async", oe, 0);
        check("mid_valid", rv, 0);
        check("mid_outst", outst, 0);
        check("mid_ready", iready, 0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        rt = -1;
        step(1'b1, 1'b0, 64'h1C0, '0, 1'b1, a);
        for (int c = 0; c < 40; c++) begin
            t_now = m_cnt;
            step(1'b0, 1'b0, '0, '0, 1'b1, a);
            if (rt < 0 && s_rv) rt = t_now;
        end
        check("post_reset_valid_cycle", rt, 30);

        // random traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            v = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            pa = {$urandom, $urandom};
            for (int k = 0; k < LW / 32; k++) rwd[k*32 +: 32] = $urandom;
            rrdy = ($urandom_range(0, 3) != 0);
            step(v, w, pa, rwd, rrdy, a);
        end
        for (int c = 0; c < 200; c++) step(1'b0, 1'b0, '0, '0, 1'b1, a);
        #1;
        check("drain_outst", outst, 0);
        check("drain_valid", rv, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
